// File: rtl/dma_controller.sv
// dma_controller -- single-channel AXI3 write DMA into a ring of 128-byte bursts.
//
// A rising edge on enable_i requests one burst. The burst has 16 beats of
// 8 bytes each. Each beat's write data is captured from data_i. Bursts start at
// BASE_ADDR and step by 128 bytes. After BUF_BURSTS bursts the address wraps
// back to BASE_ADDR. finished_o pulses once when the write response is taken.
//
// Optional feature (macro DMA_CONTROLLER_SYNC_EN):
//   defined   -- enable_i passes through a 2-flop synchronizer (awvalid rises
//                three edges after enable_i is first sampled high)
//   undefined -- enable_i is used directly (awvalid rises one edge later)
//
// Ports:
//   aclk, rst_i            clock and synchronous active-high reset
//   enable_i               asynchronous start request (rising edge = one burst)
//   data_i[63:0]           sample stream, loaded into wdata
//   finished_o             one-cycle pulse after the B handshake
//   m_axi_aw*              write-address channel (awlen/awsize/awburst constant)
//   m_axi_w*               write-data channel (wstrb constant all-ones)
//   m_axi_b*               write-response channel (bresp ignored)
//   dbg_state[1:0]         current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised, it stays high and its payload does not change
// until that edge.

module dma_controller #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned BUF_BURSTS = 1024
) (
  input  logic        aclk,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [63:0] data_i,
  output logic        finished_o,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_bready,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [31:0] BURST_BYTES = 32'd128;
  // Start address of the final burst in the ring; the pointer wraps from here.
  localparam logic [31:0] LAST_ADDR   = BASE_ADDR + BURST_BYTES * 32'(BUF_BURSTS - 1);

  logic [1:0]  state;
  logic [31:0] ptr;
  logic [3:0]  beat_cnt;
  logic        enable_meta_w;
  logic        enable_prev;
  logic        start_pulse;
  logic        bresp_unused;

  // The response code does not influence anything.
  assign bresp_unused = ^m_axi_bresp;

`ifdef DMA_CONTROLLER_SYNC_EN
  logic [1:0] enable_sync;

  always_ff @(posedge aclk) begin
    if (rst_i) enable_sync <= 2'b00;
    else       enable_sync <= {enable_sync[0], enable_i};
  end

  assign enable_meta_w = enable_sync[1];
`else
  assign enable_meta_w = enable_i;
`endif

  // The start pulse is registered. It is high for exactly one cycle after
  // enable_meta_w is first seen high. The FSM takes it only in IDLE, so a
  // request that arrives during a burst is lost.
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      enable_prev <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      enable_prev <= enable_meta_w;
      start_pulse <= enable_meta_w & ~enable_prev;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      ptr         <= BASE_ADDR;
      beat_cnt    <= 4'd0;
      m_axi_wdata <= 64'd0;
      finished_o  <= 1'b0;
    end else begin
      finished_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_pulse) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            state       <= ST_DATA;
            m_axi_wdata <= data_i;
            beat_cnt    <= 4'd0;
          end
        end
        ST_DATA: begin
          if (m_axi_wready) begin
            // The counter wraps to 0 after the last beat.
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == 4'd15) state <= ST_RESP;
            else                   m_axi_wdata <= data_i;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            state      <= ST_IDLE;
            finished_o <= 1'b1;
            ptr        <= (ptr == LAST_ADDR) ? BASE_ADDR : ptr + BURST_BYTES;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi_awaddr  = ptr;
  assign m_axi_awvalid = (state == ST_ADDR);
  assign m_axi_wvalid  = (state == ST_DATA);
  assign m_axi_wlast   = (state == ST_DATA) && (beat_cnt == 4'd15);
  assign m_axi_bready  = (state == ST_RESP);

  assign m_axi_awlen   = 4'd15;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;

  assign dbg_state     = state;

endmodule

// File: tb/tb_dma_controller.sv
// Testbench for dma_controller: AXI slave responder with configurable stalls,
// a reference model of addresses and beat data, and one summary line at the end.
// BUF_BURSTS is set to 3 so the ring wraps within a few bursts.

module tb_dma_controller;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          BURSTS = 3;
`ifdef DMA_CONTROLLER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_i;
  logic        enable_i;
  logic [63:0] data_i;
  logic        finished_o;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic        m_axi_bvalid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bready;
  logic [1:0]  dbg_state;

  dma_controller #(.BASE_ADDR(BASE), .BUF_BURSTS(BURSTS)) dut (
    .aclk(clk), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i),
    .finished_o(finished_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / model state ----------------
  logic [63:0] exp_q[$];     // expected wdata per beat, in order
  int          done_bursts;  // bursts completed since reset -> expected address
  int          beats;        // beats accepted in the current burst
  int          aw_seen;      // total AW handshakes
  bit          aw_done;      // AW accepted in the current burst
  bit          b_phase;      // last beat accepted, response outstanding
  bit          b_fired;      // B handshake on the previous edge
  bit          b_pend;
  int          b_cnt;
  int          aw_wait;
  int          wcyc;
  bit          prev_aw_stall;
  bit          prev_w_stall;
  logic [31:0] held_awaddr;
  logic [63:0] held_wdata;
  logic        held_wlast;

  // slave behaviour knobs
  int aw_delay;
  int w_mode;   // 0: always ready, 1: low every 4th cycle, 2: random
  int b_delay;

  task automatic clear_model();
    exp_q.delete();
    done_bursts   = 0;
    beats         = 0;
    aw_done       = 0;
    b_phase       = 0;
    b_fired       = 0;
    b_pend        = 0;
    b_cnt         = 0;
    aw_wait       = 0;
    wcyc          = 0;
    prev_aw_stall = 0;
    prev_w_stall  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_slave();
    m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    case (w_mode)
      0:       m_axi_wready = 1'b1;
      1:       m_axi_wready = ((wcyc % 4) != 3);
      default: m_axi_wready = ($urandom_range(0, 3) != 0);
    endcase
    if (b_pend) begin
      if (b_cnt == 0) m_axi_bvalid = 1'b1;
      else begin
        m_axi_bvalid = 1'b0;
        b_cnt--;
      end
    end else begin
      m_axi_bvalid = 1'b0;
    end
    m_axi_bresp = 2'($urandom_range(0, 3));
    data_i      = {$urandom, $urandom};
  endtask

  // Runs after the driver on the falling edge. Valid and ready seen here
  // decide what happens on the next rising edge.
  task automatic monitor();
    check("finished", 64'(finished_o), 64'(b_fired));
    b_fired = 0;

    if (prev_aw_stall) begin
      check("aw_hold_valid", 64'(m_axi_awvalid), 64'd1);
      check("aw_hold_addr", 64'(m_axi_awaddr), 64'(held_awaddr));
    end
    if (prev_w_stall) begin
      check("w_hold_valid", 64'(m_axi_wvalid), 64'd1);
      check("w_hold_data", m_axi_wdata, held_wdata);
      check("w_hold_last", 64'(m_axi_wlast), 64'(held_wlast));
    end

    if (m_axi_awvalid && m_axi_awready) begin
      check("awaddr", 64'(m_axi_awaddr), 64'(BASE + 32'(128 * (done_bursts % BURSTS))));
      aw_seen++;
      aw_done = 1;
      aw_wait = 0;
      beats   = 0;
      wcyc    = 0;
      exp_q.push_back(data_i);
    end else if (m_axi_awvalid) begin
      aw_wait++;
    end

    if (m_axi_wvalid) begin
      if (!aw_done) check("w_before_aw", 64'd1, 64'd0);
      wcyc++;
      if (m_axi_wready) begin
        check("wlast", 64'(m_axi_wlast), 64'(beats == 15));
        if (exp_q.size() == 0) check("wdata_extra_beat", 64'd1, 64'd0);
        else                   check("wdata", m_axi_wdata, exp_q.pop_front());
        if (beats < 15) exp_q.push_back(data_i);
        beats++;
        if (beats == 16) begin
          b_pend  = 1;
          b_cnt   = b_delay;
          b_phase = 1;
        end
      end
    end else if (m_axi_wlast) begin
      check("wlast_outside_data", 64'd1, 64'd0);
    end

    if (m_axi_bready && !b_phase) check("bready_early", 64'd1, 64'd0);
    if (m_axi_bvalid && m_axi_bready) begin
      b_fired = 1;
      done_bursts++;
      b_pend  = 0;
      b_phase = 0;
      aw_done = 0;
    end

    prev_aw_stall = m_axi_awvalid && !m_axi_awready;
    held_awaddr   = m_axi_awaddr;
    prev_w_stall  = m_axi_wvalid && !m_axi_wready;
    held_wdata    = m_axi_wdata;
    held_wlast    = m_axi_wlast;
  endtask

  task automatic step();
    @(negedge clk);
    drive_slave();
    monitor();
  endtask

  // One enable pulse -> one burst. inject_en pulses enable again mid-DATA;
  // reset_at7 asserts reset once seven beats have been accepted.
  task automatic run_burst(input int awd, input int wm, input int bd,
                           input bit inject_en, input bit reset_at7);
    int  start_aw;
    int  start_done;
    bit  aborted;
    aw_delay   = awd;
    w_mode     = wm;
    b_delay    = bd;
    start_aw   = aw_seen;
    start_done = done_bursts;
    aborted    = 0;

    enable_i = 1'b1;
    for (int j = 0; j <= LAT; j++) begin
      step();
      check("aw_latency", 64'(m_axi_awvalid), 64'(j == LAT));
      if (j == 1) enable_i = 1'b0;
    end
    enable_i = 1'b0;

    for (int t = 0; t < 400 && done_bursts == start_done && !aborted; t++) begin
      if (inject_en) enable_i = (beats >= 5 && beats < 8);
      if (reset_at7 && beats == 7) begin
        rst_i = 1'b1;
        clear_model();
        step();
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_bready", 64'(m_axi_bready), 64'd0);
        check("rst_wdata", m_axi_wdata, 64'd0);
        check("rst_awaddr", 64'(m_axi_awaddr), 64'(BASE));
        rst_i   = 1'b0;
        aborted = 1;
      end else begin
        step();
      end
    end
    enable_i = 1'b0;

    if (!aborted) begin
      check("burst_done", 64'(done_bursts - start_done), 64'd1);
      check("beat_count", 64'(beats), 64'd16);
      check("aw_count", 64'(aw_seen - start_aw), 64'd1);
    end
    // Idle gap: no stray AW may follow (dropped request, reset).
    start_aw = aw_seen;
    for (int k = 0; k < 8; k++) step();
    check("no_stray_aw", 64'(aw_seen - start_aw), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i         = 1'b1;
    enable_i      = 1'b0;
    data_i        = 64'd0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    aw_seen       = 0;
    aw_delay      = 0;
    w_mode        = 0;
    b_delay       = 0;
    clear_model();

    for (int i = 0; i < 3; i++) step();
    check("reset_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("reset_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("reset_wlast", 64'(m_axi_wlast), 64'd0);
    check("reset_bready", 64'(m_axi_bready), 64'd0);
    check("reset_finished", 64'(finished_o), 64'd0);
    check("reset_wdata", m_axi_wdata, 64'd0);
    check("reset_awaddr", 64'(m_axi_awaddr), 64'(BASE));
    check("const_awlen", 64'(m_axi_awlen), 64'd15);
    check("const_awsize", 64'(m_axi_awsize), 64'd3);
    check("const_awburst", 64'(m_axi_awburst), 64'd1);
    check("const_wstrb", 64'(m_axi_wstrb), 64'hFF);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) step();

    run_burst(0, 0, 0, 0, 0);    // no stalls, BASE
    run_burst(3, 1, 3, 0, 0);    // AW/W/B stalls, BASE+128
    run_burst(0, 0, 0, 1, 0);    // enable during DATA dropped, BASE+256
    run_burst($urandom_range(0, 4), 2, $urandom_range(0, 4), 0, 0);  // wraps to BASE
    run_burst($urandom_range(0, 4), 2, $urandom_range(0, 4), 0, 0);  // BASE+128
    run_burst(1, 0, 1, 0, 1);    // reset at beat 7
    run_burst(0, 0, 0, 0, 0);    // restarts at BASE
    for (int r = 0; r < 4; r++)
      run_burst($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 5), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
